// File: rtl/mux8_arbiter_if.sv
// Request/grant bundle between eight requesters and the mux8 round-robin arbiter.
// master = requester side, slave = arbiter side.
interface mux8_arbiter_if;
  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] sel;
  logic             busy;
  logic             done;

  modport master (output req, input grant, sel, busy, done);
  modport slave  (input req, output grant, sel, busy, done);
endinterface

// File: rtl/mux8_arbiter.sv
// Round-robin arbiter driving the select lines of a shared mux8 (sel[2:0] -> s2..s0).
// Optional tenure-limit preemption enabled by defining MUX8_ARB_TIMEOUT_EN.
module mux8_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  mux8_arbiter_if.slave  arb
);
  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] sel_q,   sel_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic [N_REQ-1:0] others_c;
  logic [IDX_W:0]   pick_all_c;
  logic [IDX_W:0]   pick_oth_c;

  // First set bit searching from p+1 upward, modulo 8; MSB of result flags a hit.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [IDX_W-1:0] p);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      cand = p + IDX_W'(k);
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  // In GRANT, ptr_q equals the current holder, so both searches start after it.
  always_comb begin
    others_c   = arb.req & ~(N_REQ'(1) << sel_q);
    pick_all_c = rr_pick(arb.req, ptr_q);
    pick_oth_c = rr_pick(others_c, ptr_q);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pick_all_c[IDX_W]) begin
          grant_d = N_REQ'(1) << pick_all_c[IDX_W-1:0];
          sel_d   = pick_all_c[IDX_W-1:0];
          ptr_d   = pick_all_c[IDX_W-1:0];
          cnt_d   = CNT_W'(1);
          busy_d  = 1'b1;
          state_d = S_GRANT;
        end
      end

      S_GRANT: begin
        if (!arb.req[sel_q]) begin
          done_d = 1'b1;
          if (pick_oth_c[IDX_W]) begin
            grant_d = N_REQ'(1) << pick_oth_c[IDX_W-1:0];
            sel_d   = pick_oth_c[IDX_W-1:0];
            ptr_d   = pick_oth_c[IDX_W-1:0];
            cnt_d   = CNT_W'(1);
          end else begin
            grant_d = '0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          if (cnt_q != CNT_W'(HOLD_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`ifdef MUX8_ARB_TIMEOUT_EN
          // Tenure exhausted and someone else waiting: hand off on this edge.
          if ((cnt_q == CNT_W'(HOLD_MAX)) && pick_oth_c[IDX_W]) begin
            done_d  = 1'b1;
            grant_d = N_REQ'(1) << pick_oth_c[IDX_W-1:0];
            sel_d   = pick_oth_c[IDX_W-1:0];
            ptr_d   = pick_oth_c[IDX_W-1:0];
            cnt_d   = CNT_W'(1);
          end
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= IDX_W'(N_REQ - 1);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign arb.grant = grant_q;
  assign arb.sel   = sel_q;
  assign arb.busy  = busy_q;
  assign arb.done  = done_q;
endmodule

// File: tb/tb_mux8_arbiter.sv
// Directed bench for mux8_arbiter; expected values are hand-computed per step.
// Timeout expectations follow MUX8_ARB_TIMEOUT_EN when the bench is built with it.
module tb_mux8_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mux8_arbiter_if bus ();

  mux8_arbiter #(.HOLD_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] g, input logic [2:0] s,
                         input logic b, input logic d);
    chk({tag, ".grant"}, bus.grant, g);
    chk({tag, ".sel"},   8'(bus.sel), 8'(s));
    chk({tag, ".busy"},  8'(bus.busy), 8'(b));
    chk({tag, ".done"},  8'(bus.done), 8'(d));
  endtask

  initial begin
    logic [7:0] exp_g;
    logic       exp_d;
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    bus.req = 8'hFF;

    // Reset held two cycles with all requests up
    step();
    step();
    chk_all("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    chk_all("first_grant", 8'h01, 3'd0, 1'b1, 1'b0);
    bus.req = 8'h00;
    step();
    chk_all("first_release", 8'h00, 3'd0, 1'b0, 1'b1);
    step();
    chk_all("idle_after_release", 8'h00, 3'd0, 1'b0, 1'b0);

    // Single requester 5
    bus.req = 8'h20;
    step();
    chk_all("single_grant", 8'h20, 3'd5, 1'b1, 1'b0);
    bus.req = 8'h00;
    step();
    chk_all("single_release", 8'h00, 3'd5, 1'b0, 1'b1);
    step();
    chk_all("single_idle", 8'h00, 3'd5, 1'b0, 1'b0);

    // Rotation between 0 and 7; ptr=5 so 7 wins first
    bus.req = 8'h81;
    step();
    chk_all("rot_g7a", 8'h80, 3'd7, 1'b1, 1'b0);
    step();
    chk_all("rot_g7a_hold", 8'h80, 3'd7, 1'b1, 1'b0);
    bus.req = 8'h01;
    step();
    chk_all("rot_g0a", 8'h01, 3'd0, 1'b1, 1'b1);
    bus.req = 8'h81;
    step();
    chk_all("rot_g0a_hold", 8'h01, 3'd0, 1'b1, 1'b0);
    bus.req = 8'h80;
    step();
    chk_all("rot_g7b", 8'h80, 3'd7, 1'b1, 1'b1);
    bus.req = 8'h81;
    step();
    chk_all("rot_g7b_hold", 8'h80, 3'd7, 1'b1, 1'b0);
    bus.req = 8'h01;
    step();
    chk_all("rot_g0b", 8'h01, 3'd0, 1'b1, 1'b1);
    bus.req = 8'h00;
    step();
    chk_all("rot_end", 8'h00, 3'd0, 1'b0, 1'b1);

    // Wrap-around: holder 7 releases while 2 and 3 request
    bus.req = 8'h80;
    step();
    chk_all("wrap_g7", 8'h80, 3'd7, 1'b1, 1'b0);
    bus.req = 8'h0C;
    step();
    chk_all("wrap_g2", 8'h04, 3'd2, 1'b1, 1'b1);
    bus.req = 8'h00;
    step();
    chk_all("wrap_end", 8'h00, 3'd2, 1'b0, 1'b1);
    step();

    // Constant req=03: timeout alternation or indefinite hold
    bus.req = 8'h03;
    for (int k = 1; k <= 9; k++) begin
      step();
`ifdef MUX8_ARB_TIMEOUT_EN
      exp_g = ((((k - 1) / 4) % 2) == 1) ? 8'h02 : 8'h01;
      exp_d = (k > 1) && (((k - 1) % 4) == 0);
`else
      exp_g = 8'h01;
      exp_d = 1'b0;
`endif
      chk_all($sformatf("hold_k%0d", k), exp_g, (exp_g == 8'h02) ? 3'd1 : 3'd0, 1'b1, exp_d);
    end
    bus.req = 8'h00;
    step();
    chk("hold_end.grant", bus.grant, 8'h00);
    chk("hold_end.done", 8'(bus.done), 8'h01);
    step();

    // Reset mid-grant drops the grant without done and restores ptr=7
    bus.req = 8'h10;
    step();
    chk_all("mid_g4", 8'h10, 3'd4, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    chk_all("mid_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    bus.req = 8'h30;
    step();
    chk_all("post_reset_pick", 8'h10, 3'd4, 1'b1, 1'b0);
    bus.req = 8'h00;
    step();
    chk_all("post_reset_release", 8'h00, 3'd4, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
